// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI4 slave terminating one master port in a word-addressed register array
module axi_sram_responder #(
  parameter int                    ID_WIDTH   = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [ID_WIDTH-1:0]     s_axi_AWID,
  input  logic [ADDR_WIDTH-1:0]   s_axi_AWADDR,
  input  logic [7:0]              s_axi_AWLEN,
  input  logic [2:0]              s_axi_AWSIZE,
  input  logic [1:0]              s_axi_AWBURST,
  input  logic                    s_axi_AWLOCK,
  input  logic [3:0]              s_axi_AWCACHE,
  input  logic [2:0]              s_axi_AWPROT,
  input  logic [3:0]              s_axi_AWREGION,
  input  logic                    s_axi_AWVALID,
  output logic                    s_axi_AWREADY,
  input  logic [DATA_WIDTH-1:0]   s_axi_WDATA,
  input  logic [DATA_WIDTH/8-1:0] s_axi_WSTRB,
  input  logic                    s_axi_WLAST,
  input  logic                    s_axi_WVALID,
  output logic                    s_axi_WREADY,
  output logic [ID_WIDTH-1:0]     s_axi_BID,
  output logic [1:0]              s_axi_BRESP,
  output logic                    s_axi_BVALID,
  input  logic                    s_axi_BREADY,
  input  logic [ID_WIDTH-1:0]     s_axi_ARID,
  input  logic [ADDR_WIDTH-1:0]   s_axi_ARADDR,
  input  logic [7:0]              s_axi_ARLEN,
  input  logic [2:0]              s_axi_ARSIZE,
  input  logic [1:0]              s_axi_ARBURST,
  input  logic                    s_axi_ARLOCK,
  input  logic [3:0]              s_axi_ARCACHE,
  input  logic [2:0]              s_axi_ARPROT,
  input  logic [3:0]              s_axi_ARREGION,
  input  logic                    s_axi_ARVALID,
  output logic                    s_axi_ARREADY,
  output logic [ID_WIDTH-1:0]     s_axi_RID,
  output logic [DATA_WIDTH-1:0]   s_axi_RDATA,
  output logic [1:0]              s_axi_RRESP,
  output logic                    s_axi_RLAST,
  output logic                    s_axi_RVALID,
  input  logic                    s_axi_RREADY
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(NB);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + step) & mask);
      default: return a + step;
    endcase
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> LOG2B) < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[LOG2B +: IDX_W];
  endfunction

  // Range failure dominates every other per-beat error.
  function automatic logic [1:0] beat_resp(input logic ok, input logic bad);
    return !ok ? RESP_DECERR : (bad ? RESP_SLVERR : RESP_OKAY);
  endfunction

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- write channel ----------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst, w_err, w_beat_resp;
  logic                  w_size_bad, w_beat_ok, w_last_beat, mem_we;

  assign w_size_bad  = w_size > 3'(LOG2B);
  assign w_beat_ok   = in_range(w_addr);
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_resp = resp_max(beat_resp(w_beat_ok, w_size_bad || (w_burst == 2'b11)),
                                (s_axi_WLAST != w_last_beat) ? RESP_SLVERR : RESP_OKAY);
  assign mem_we      = (w_state == W_DATA) && s_axi_WVALID && w_beat_ok && !w_size_bad;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) w_state <= W_IDLE;
    else         w_state <= w_next;
  end

  always_comb begin
    w_next        = w_state;
    s_axi_AWREADY = 1'b0;
    s_axi_WREADY  = 1'b0;
    s_axi_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_AWREADY = 1'b1;
        if (s_axi_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_WREADY = 1'b1;
        if (s_axi_WVALID && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_BVALID = 1'b1;
        if (s_axi_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= RESP_OKAY;
    end else if (w_state == W_IDLE && s_axi_AWVALID) begin
      w_id    <= s_axi_AWID;
      w_addr  <= s_axi_AWADDR;
      w_len   <= s_axi_AWLEN;
      w_cnt   <= '0;
      w_size  <= s_axi_AWSIZE;
      w_burst <= s_axi_AWBURST;
      w_err   <= RESP_OKAY;
    end else if (w_state == W_DATA && s_axi_WVALID) begin
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
      w_cnt  <= 8'(w_cnt + 8'd1);
      w_err  <= resp_max(w_err, w_beat_resp);
    end
  end

  assign s_axi_BID   = w_id;
  assign s_axi_BRESP = w_err;

  // Memory is deliberately left out of reset so committed writes survive it.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_WSTRB[b]) mem[word_idx(w_addr)][b*8 +: 8] <= s_axi_WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_load_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size, r_load_size;
  logic [1:0]            r_burst, r_load_burst, r_beat_resp;
  logic [DATA_WIDTH-1:0] r_beat_data;
  logic                  r_beat_ok, r_beat_size_bad;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_ARREADY = 1'b0;
    s_axi_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_ARREADY = 1'b1;
        if (s_axi_ARVALID) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_RVALID = 1'b1;
        if (s_axi_RREADY && s_axi_RLAST) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // The beat to load is either beat 0 of a new request or the successor of the current beat.
  always_comb begin
    r_load_addr  = next_addr(r_addr, r_len, r_size, r_burst);
    r_load_size  = r_size;
    r_load_burst = r_burst;
    if (r_state == R_IDLE) begin
      r_load_addr  = s_axi_ARADDR;
      r_load_size  = s_axi_ARSIZE;
      r_load_burst = s_axi_ARBURST;
    end
    r_beat_ok       = in_range(r_load_addr);
    r_beat_size_bad = r_load_size > 3'(LOG2B);
    r_beat_resp     = beat_resp(r_beat_ok, r_beat_size_bad || (r_load_burst == 2'b11));
    r_beat_data     = (r_beat_ok && !r_beat_size_bad) ? mem[word_idx(r_load_addr)] : '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s_axi_RID   <= '0;
      s_axi_RDATA <= '0;
      s_axi_RRESP <= RESP_OKAY;
      s_axi_RLAST <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
    end else if (r_state == R_IDLE && s_axi_ARVALID) begin
      s_axi_RID   <= s_axi_ARID;
      s_axi_RDATA <= r_beat_data;
      s_axi_RRESP <= r_beat_resp;
      s_axi_RLAST <= (s_axi_ARLEN == 8'd0);
      r_addr      <= s_axi_ARADDR;
      r_len       <= s_axi_ARLEN;
      r_cnt       <= '0;
      r_size      <= s_axi_ARSIZE;
      r_burst     <= s_axi_ARBURST;
    end else if (r_state == R_DATA && s_axi_RREADY) begin
      if (s_axi_RLAST) begin
        s_axi_RLAST <= 1'b0;
      end else begin
        s_axi_RDATA <= r_beat_data;
        s_axi_RRESP <= r_beat_resp;
        s_axi_RLAST <= (8'(r_cnt + 8'd1) == r_len);
        r_addr      <= r_load_addr;
        r_cnt       <= 8'(r_cnt + 8'd1);
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_AWLOCK, s_axi_AWCACHE, s_axi_AWPROT, s_axi_AWREGION,
                           s_axi_ARLOCK, s_axi_ARCACHE, s_axi_ARPROT, s_axi_ARREGION};

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - scoreboard bench for axi_sram_responder
module tb_axi_sram_responder;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic         clock, resetn;
  logic [1:0]   s_axi_AWID, s_axi_AWBURST, s_axi_BID, s_axi_BRESP;
  logic [31:0]  s_axi_AWADDR, s_axi_ARADDR;
  logic [7:0]   s_axi_AWLEN, s_axi_ARLEN;
  logic [2:0]   s_axi_AWSIZE, s_axi_ARSIZE;
  logic         s_axi_AWVALID, s_axi_AWREADY, s_axi_WLAST, s_axi_WVALID, s_axi_WREADY;
  logic [127:0] s_axi_WDATA, s_axi_RDATA;
  logic [15:0]  s_axi_WSTRB;
  logic         s_axi_BVALID, s_axi_BREADY, s_axi_ARVALID, s_axi_ARREADY;
  logic [1:0]   s_axi_ARID, s_axi_ARBURST, s_axi_RID, s_axi_RRESP;
  logic         s_axi_RLAST, s_axi_RVALID, s_axi_RREADY;

  axi_sram_responder dut (
    .clock(clock), .resetn(resetn),
    .s_axi_AWID(s_axi_AWID), .s_axi_AWADDR(s_axi_AWADDR), .s_axi_AWLEN(s_axi_AWLEN),
    .s_axi_AWSIZE(s_axi_AWSIZE), .s_axi_AWBURST(s_axi_AWBURST), .s_axi_AWLOCK(1'b0),
    .s_axi_AWCACHE(4'h0), .s_axi_AWPROT(3'h0), .s_axi_AWREGION(4'h0),
    .s_axi_AWVALID(s_axi_AWVALID), .s_axi_AWREADY(s_axi_AWREADY),
    .s_axi_WDATA(s_axi_WDATA), .s_axi_WSTRB(s_axi_WSTRB), .s_axi_WLAST(s_axi_WLAST),
    .s_axi_WVALID(s_axi_WVALID), .s_axi_WREADY(s_axi_WREADY),
    .s_axi_BID(s_axi_BID), .s_axi_BRESP(s_axi_BRESP), .s_axi_BVALID(s_axi_BVALID),
    .s_axi_BREADY(s_axi_BREADY),
    .s_axi_ARID(s_axi_ARID), .s_axi_ARADDR(s_axi_ARADDR), .s_axi_ARLEN(s_axi_ARLEN),
    .s_axi_ARSIZE(s_axi_ARSIZE), .s_axi_ARBURST(s_axi_ARBURST), .s_axi_ARLOCK(1'b0),
    .s_axi_ARCACHE(4'h0), .s_axi_ARPROT(3'h0), .s_axi_ARREGION(4'h0),
    .s_axi_ARVALID(s_axi_ARVALID), .s_axi_ARREADY(s_axi_ARREADY),
    .s_axi_RID(s_axi_RID), .s_axi_RDATA(s_axi_RDATA), .s_axi_RRESP(s_axi_RRESP),
    .s_axi_RLAST(s_axi_RLAST), .s_axi_RVALID(s_axi_RVALID), .s_axi_RREADY(s_axi_RREADY)
  );

  typedef struct packed {
    logic [1:0]   id;
    logic [1:0]   resp;
    logic         last;
    logic [127:0] data;
  } r_exp_t;

  r_exp_t       r_q[$];
  logic [3:0]   b_q[$];
  logic [127:0] model [0:15];
  logic [127:0] wbuf [0:15];
  logic [15:0]  sbuf [0:15];
  int           n_compared = 0, n_mismatched = 0;
  logic         rr_toggle = 1'b0, rr_hold = 1'b0;
  logic         stall_prev = 1'b0;
  logic [132:0] held;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!resetn) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && s_axi_RVALID)
        check_eq("r_stable", {s_axi_RID, s_axi_RRESP, s_axi_RLAST, s_axi_RDATA}, held);
      if (s_axi_RVALID && s_axi_RREADY) begin
        if (r_q.size() == 0) check_eq("r_unexpected", r_q.size(), 1);
        else check_eq("r_beat", {s_axi_RID, s_axi_RRESP, s_axi_RLAST, s_axi_RDATA}, r_q.pop_front());
      end
      stall_prev <= s_axi_RVALID && !s_axi_RREADY;
      held       <= {s_axi_RID, s_axi_RRESP, s_axi_RLAST, s_axi_RDATA};
      if (s_axi_BVALID && s_axi_BREADY) begin
        if (b_q.size() == 0) check_eq("b_unexpected", b_q.size(), 1);
        else check_eq("b_resp", {s_axi_BID, s_axi_BRESP}, b_q.pop_front());
      end
    end
  end

  // RREADY is either held low, toggled every cycle, or held high.
  initial begin
    s_axi_RREADY = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      s_axi_RREADY = rr_hold ? 1'b0 : (rr_toggle ? ~s_axi_RREADY : 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_write(input int idx, input logic [127:0] d, input logic [15:0] s);
    for (int b = 0; b < 16; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic push_r(input logic [1:0] id, input logic [1:0] resp, input logic last, input logic [127:0] d);
    r_exp_t e;
    e.id = id; e.resp = resp; e.last = last; e.data = d;
    r_q.push_back(e);
  endtask

  // Returns at posedge+1 after the edge on which the handshake occurred.
  task automatic wait_hs(input int ch, input string tag);
    logic done;
    int   n;
    done = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      case (ch)
        0:       done = s_axi_AWREADY;
        1:       done = s_axi_WREADY;
        default: done = s_axi_ARREADY;
      endcase
      @(posedge clock);
      #1;
      n++;
    end
    check_eq(tag, done, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    check_eq("drain", r_q.size() + b_q.size(), 0);
  endtask

  task automatic axi_write(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] exp_resp, input int last_bad);
    b_q.push_back({id, exp_resp});
    s_axi_AWID = id; s_axi_AWADDR = addr; s_axi_AWLEN = len;
    s_axi_AWSIZE = size; s_axi_AWBURST = burst; s_axi_AWVALID = 1'b1;
    wait_hs(0, "aw_hs");
    s_axi_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_WDATA = wbuf[i]; s_axi_WSTRB = sbuf[i];
      s_axi_WLAST = (i == int'(len)) ^ (i == last_bad);
      s_axi_WVALID = 1'b1;
      wait_hs(1, "w_hs");
      s_axi_WVALID = 1'b0;
    end
    check_eq("b_latency", s_axi_BVALID, 1'b1);
    wait_drain();
  endtask

  task automatic axi_read(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic drain);
    s_axi_ARID = id; s_axi_ARADDR = addr; s_axi_ARLEN = len;
    s_axi_ARSIZE = size; s_axi_ARBURST = burst; s_axi_ARVALID = 1'b1;
    wait_hs(2, "ar_hs");
    s_axi_ARVALID = 1'b0;
    if (drain) wait_drain();
  endtask

  initial begin
    resetn = 1'b0;
    s_axi_AWVALID = 0; s_axi_WVALID = 0; s_axi_ARVALID = 0; s_axi_BREADY = 1;
    s_axi_AWID = 0; s_axi_AWADDR = 0; s_axi_AWLEN = 0; s_axi_AWSIZE = 0; s_axi_AWBURST = 0;
    s_axi_WDATA = 0; s_axi_WSTRB = 0; s_axi_WLAST = 0;
    s_axi_ARID = 0; s_axi_ARADDR = 0; s_axi_ARLEN = 0; s_axi_ARSIZE = 0; s_axi_ARBURST = 0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_ready", {s_axi_AWREADY, s_axi_ARREADY, s_axi_WREADY}, 3'b110);
    check_eq("rst_valid", {s_axi_BVALID, s_axi_RVALID, s_axi_RLAST}, 3'b000);
    check_eq("rst_fields", {s_axi_BID, s_axi_BRESP, s_axi_RID, s_axi_RRESP, s_axi_RDATA}, 0);
    resetn = 1'b1;

    // single write then read
    wbuf[0] = {16{8'hA5}}; sbuf[0] = 16'hFFFF;
    model_write(1, wbuf[0], sbuf[0]);
    axi_write(2'd1, 32'h10, 8'd0, 3'd4, INCR, OKAY, -1);
    push_r(2'd2, OKAY, 1'b1, {16{8'hA5}});
    axi_read(2'd2, 32'h10, 8'd0, 3'd4, INCR, 1'b1);

    // prefill words 0..3, then a strobed INCR burst over them
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = '1; sbuf[i] = 16'hFFFF; model_write(i, wbuf[i], sbuf[i]);
    end
    axi_write(2'd0, 32'h0, 8'd3, 3'd4, INCR, OKAY, -1);
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = {4{32'hC0DE_0000 + 32'(i)}}; sbuf[i] = 16'h00FF; model_write(i, wbuf[i], sbuf[i]);
    end
    axi_write(2'd1, 32'h0, 8'd3, 3'd4, INCR, OKAY, -1);
    for (int i = 0; i < 4; i++)
      push_r(2'd1, OKAY, i == 3, {64'hFFFF_FFFF_FFFF_FFFF, {2{32'hC0DE_0000 + 32'(i)}}});
    axi_read(2'd1, 32'h0, 8'd3, 3'd4, INCR, 1'b1);

    // WRAP4 from 0x30 visits words 3,0,1,2
    push_r(2'd3, OKAY, 1'b0, model[3]);
    push_r(2'd3, OKAY, 1'b0, model[0]);
    push_r(2'd3, OKAY, 1'b0, model[1]);
    push_r(2'd3, OKAY, 1'b1, model[2]);
    axi_read(2'd3, 32'h30, 8'd3, 3'd4, WRAP, 1'b1);

    // 8-beat read under RREADY back-pressure
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = {4{32'hB000_0000 + 32'(i) * 32'h111}}; sbuf[i] = 16'hFFFF;
      model_write(4 + i, wbuf[i], sbuf[i]);
    end
    axi_write(2'd2, 32'h40, 8'd7, 3'd4, INCR, OKAY, -1);
    for (int i = 0; i < 8; i++) push_r(2'd1, OKAY, i == 7, model[4 + i]);
    rr_toggle = 1'b1;
    axi_read(2'd1, 32'h40, 8'd7, 3'd4, INCR, 1'b1);
    rr_toggle = 1'b0;

    // out-of-range and oversize accesses
    wbuf[0] = 128'h1234_5678; sbuf[0] = 16'hFFFF;
    axi_write(2'd2, 32'h4000, 8'd0, 3'd4, INCR, DECERR, -1);
    push_r(2'd0, OKAY, 1'b1, model[0]);
    axi_read(2'd0, 32'h0, 8'd0, 3'd4, INCR, 1'b1);
    push_r(2'd2, DECERR, 1'b1, 128'h0);
    axi_read(2'd2, 32'h4000, 8'd0, 3'd4, INCR, 1'b1);
    wbuf[0] = 128'hDEAD_BEEF;
    axi_write(2'd3, 32'h20, 8'd0, 3'd5, INCR, SLVERR, -1);
    push_r(2'd3, OKAY, 1'b1, model[2]);
    axi_read(2'd3, 32'h20, 8'd0, 3'd4, INCR, 1'b1);

    // early WLAST flags SLVERR but the beats still land
    for (int i = 0; i < 2; i++) begin
      wbuf[i] = {4{32'h5A5A_0000 + 32'(i)}}; sbuf[i] = 16'hFFFF; model_write(12 + i, wbuf[i], sbuf[i]);
    end
    axi_write(2'd1, 32'hC0, 8'd1, 3'd4, INCR, SLVERR, 0);
    push_r(2'd0, OKAY, 1'b0, model[12]);
    push_r(2'd0, OKAY, 1'b1, model[13]);
    axi_read(2'd0, 32'hC0, 8'd1, 3'd4, INCR, 1'b1);

    // reset in the middle of a 4-beat write while a read beat is stalled
    rr_hold = 1'b1;
    @(posedge clock);
    #1;
    axi_read(2'd1, 32'h0, 8'd0, 3'd4, INCR, 1'b0);
    s_axi_AWID = 2'd1; s_axi_AWADDR = 32'h80; s_axi_AWLEN = 8'd3;
    s_axi_AWSIZE = 3'd4; s_axi_AWBURST = INCR; s_axi_AWVALID = 1'b1;
    wait_hs(0, "aw_hs");
    s_axi_AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wbuf[i] = {4{32'h7777_0000 + 32'(i)}}; sbuf[i] = 16'hFFFF; model_write(8 + i, wbuf[i], sbuf[i]);
      s_axi_WDATA = wbuf[i]; s_axi_WSTRB = sbuf[i]; s_axi_WLAST = 1'b0; s_axi_WVALID = 1'b1;
      wait_hs(1, "w_hs");
      s_axi_WVALID = 1'b0;
    end
    check_eq("pre_rst_busy", {s_axi_RVALID, s_axi_WREADY}, 2'b11);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", {s_axi_BVALID, s_axi_RVALID, s_axi_WREADY}, 3'b000);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    rr_hold = 1'b0;
    check_eq("post_rst_ready", {s_axi_AWREADY, s_axi_ARREADY}, 2'b11);
    for (int i = 0; i < 4; i++) push_r(2'd2, OKAY, i == 3, model[8 + i]);
    axi_read(2'd2, 32'h80, 8'd3, 3'd4, INCR, 1'b1);

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
